hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Pipeline control block for the decode stage: tracks in-flight register writes and stalls decode on RAW/WAW hazards against the register file read addresses.
- Generates fetch/decode stall and decode/execute flush on taken branches, and clears pending entries for instructions squashed in execute.
- Sits beside the decode stage, between the control unit and the pipeline registers.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- WIDTH, 8, width of the stall performance counter.
- NREGS, 16, number of architectural registers; the scoreboard has NREGS bits.
- PC_REG, 15, register index that is never tracked, because it is read as PCPlus8.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RA1D  in  4  decode read address 1.
- RA2D  in  4  decode read address 2.
- UseRA1D  in  1  instruction in D really reads RA1D.
- UseRA2D  in  1  instruction in D really reads RA2D.
- ValidD  in  1  D holds a valid instruction.
- RegWriteD  in  1  D instruction writes a register.
- WA3D  in  4  destination of the D instruction.
- SquashE  in  1  E instruction failed its condition; it will not write back.
- WA3E  in  4  destination of the E instruction.
- RegWriteE  in  1  E instruction was marked as writing.
- RegWriteW  in  1  writeback this cycle.
- WA3W  in  4  writeback destination.
- BranchTakenE  in  1  taken branch resolved in E.
- StallF  out  1  hold PC.
- StallD  out  1  hold the D pipeline register.
- FlushD  out  1  bubble D.
- FlushE  out  1  bubble E.
- Busy  out  1  any scoreboard bit set.
- StallCount  out  WIDTH  saturating count of stalled cycles.

Behaviour:
- Reset (reset=0, async): scoreboard = 0, FSM = RUN, StallCount = 0; all outputs 0.
- Pending(r) = scoreboard[r], with the writeback qualification given under the optional feature. Index PC_REG is always not pending.
- Hazard = ValidD & ((UseRA1D & Pending(RA1D)) | (UseRA2D & Pending(RA2D)) | (RegWriteD & Pending(WA3D))).
- Issue = ValidD & ~Hazard & ~BranchTakenE & FSM≠FLUSH.
- Scoreboard update on each rising edge:
  - Clear bit WA3W when RegWriteW=1.
  - Clear bit WA3E when SquashE & RegWriteE.
  - Set bit WA3D when Issue & RegWriteD & WA3D≠PC_REG.
  - Set beats clear on the same index. Under the WAW stall this occurs only in bypass mode.
- FSM states and transitions:
  - RUN: Hazard → StallF = StallD = 1 and FlushE = 1 (bubble into E); go to STALL.
  - STALL: same outputs while Hazard holds; return to RUN on the first cycle with ~Hazard, in which the instruction issues.
  - BranchTakenE in any state: FlushD = FlushE = 1 that cycle, stalls forced to 0, go to FLUSH.
  - FLUSH: FlushD = 1 for one more cycle (drops the second wrong-path fetch), then RUN.
  - Priority: BranchTakenE > Hazard.
- Stall/flush outputs are combinational from the state and the current inputs, so a hazard is visible in the cycle it occurs (0-cycle latency).
- Busy = |scoreboard, registered view.
- StallCount increments each cycle StallD=1 and saturates at 2^WIDTH−1. It is not cleared except by reset.
- reset asserted mid-stall: all pending bits dropped immediately and FSM = RUN. Software must restart the pipeline.

Optional Feature:
- Macro: HAZARD_WB_BYPASS_EN.
- Defined: the register file writes in the first half-cycle, so Pending(r) = scoreboard[r] & ~(RegWriteW & WA3W==r). A writeback in the same cycle as the dependent read causes no stall.
- Undefined: Pending(r) = scoreboard[r]. The dependent instruction stalls through the writeback cycle and issues the cycle after, one extra stall cycle.

Test Plan:
- Reset with scoreboard dirty: issue writes to R3 and R5, pulse reset=0 → Busy=0, StallCount=0, all outputs 0 asynchronously.
- RAW: issue RegWriteD=1, WA3D=4; next cycle RA1D=4, UseRA1D=1 → StallD=StallF=FlushE=1 until RegWriteW with WA3W=4.
  - Bypass defined: 0 extra stall cycles after writeback.
  - Bypass undefined: stall held one cycle past the writeback cycle.
  - StallCount equals the stalled cycles.
- WAW and PC: pending R7, D writes WA3D=7 → stall. WA3D=15 or RA1D=15 → never stalls, bit 15 never set.
- Squash: issue write R2, then SquashE=1, RegWriteE=1, WA3E=2 → bit 2 cleared; a later reader of R2 has no stall; Busy=0.
- Branch during stall: in STALL, BranchTakenE=1 → FlushD=FlushE=1, StallD=0; next cycle FlushD=1 only; then RUN. The flushed D instruction sets no pending bit.
- Saturation: WIDTH=4, hold a hazard 20 cycles → StallCount=15.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Decode-stage hazard control. Keeps one pending bit per architectural
// register for every issued instruction that will write that register. Decode
// stalls on RAW (a used read address is pending) and WAW (the destination is
// pending). A taken branch resolved in E flushes D and E and, one cycle later,
// D again to drop the second wrong-path fetch. A saturating counter records
// the number of stalled cycles.
//
// Configuration macro:
//   HAZARD_WB_BYPASS_EN - the register file writes in the first half-cycle,
//                         so a writeback in the same cycle as the dependent
//                         read hides the pending bit (no extra stall cycle).
//                         Undefined: the reader stalls through the writeback
//                         cycle and issues the cycle after.
//
// Parameters:
//   WIDTH  - width of the stall performance counter
//   NREGS  - number of architectural registers (scoreboard bits)
//   PC_REG - register index that is never tracked (read as PCPlus8)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   RA1D, RA2D   in   decode read addresses
//   UseRA1D/2D   in   the D instruction really reads RA1D / RA2D
//   ValidD       in   D holds a valid instruction
//   RegWriteD    in   D instruction writes register WA3D
//   WA3D         in   destination of the D instruction
//   SquashE      in   E instruction failed its condition (no writeback)
//   WA3E         in   destination of the E instruction
//   RegWriteE    in   E instruction was marked as writing
//   RegWriteW    in   writeback this cycle
//   WA3W         in   writeback destination
//   BranchTakenE in   taken branch resolved in E
//   StallF       out  hold PC
//   StallD       out  hold the D pipeline register
//   FlushD       out  bubble D
//   FlushE       out  bubble E
//   Busy         out  any scoreboard bit set (registered)
//   StallCount   out  saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int WIDTH  = 8,
    parameter int NREGS  = 16,
    parameter int PC_REG = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic             UseRA1D,
    input  logic             UseRA2D,
    input  logic             ValidD,
    input  logic             RegWriteD,
    input  logic [3:0]       WA3D,
    input  logic             SquashE,
    input  logic [3:0]       WA3E,
    input  logic             RegWriteE,
    input  logic             RegWriteW,
    input  logic [3:0]       WA3W,
    input  logic             BranchTakenE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             Busy,
    output logic [WIDTH-1:0] StallCount
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0]       PC_IDX  = 4'(PC_REG);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next_s;
    logic [NREGS-1:0] sb_r;
    logic [NREGS-1:0] sb_next_s;
    logic [NREGS-1:0] wb_mask_s;
    logic [NREGS-1:0] pend_vec_s;
    logic [NREGS-1:0] clr_w_s;
    logic [NREGS-1:0] clr_e_s;
    logic [NREGS-1:0] set_s;
    logic             busy_r;
    logic [WIDTH-1:0] stall_cnt_r;
    logic             hazard_s;
    logic             issue_s;
    logic             stall_s;
    logic             flush_d_s;
    logic             flush_e_s;

    // Same-cycle writeback mask that hides a pending bit when bypass is built in
    always_comb begin
        wb_mask_s = '0;
`ifdef HAZARD_WB_BYPASS_EN
        wb_mask_s[WA3W] = RegWriteW;
`else
        wb_mask_s = '0;
`endif
    end

    // Effective pending vector; the PC register is never treated as pending
    always_comb begin
        pend_vec_s         = sb_r & ~wb_mask_s;
        pend_vec_s[PC_IDX] = 1'b0;
    end

    assign hazard_s = ValidD & ((UseRA1D   & pend_vec_s[RA1D]) |
                                (UseRA2D   & pend_vec_s[RA2D]) |
                                (RegWriteD & pend_vec_s[WA3D]));

    // Stall/flush decode and next state; branch outranks any hazard
    always_comb begin
        stall_s      = 1'b0;
        flush_d_s    = 1'b0;
        flush_e_s    = 1'b0;
        issue_s      = 1'b0;
        state_next_s = ST_RUN;
        if (BranchTakenE) begin
            flush_d_s    = 1'b1;
            flush_e_s    = 1'b1;
            state_next_s = ST_FLUSH;
        end else begin
            case (state_r)
                ST_FLUSH: begin
                    // D holds the second wrong-path fetch: drop it, never issue it
                    flush_d_s    = 1'b1;
                    state_next_s = ST_RUN;
                end
                ST_RUN, ST_STALL: begin
                    if (hazard_s) begin
                        stall_s      = 1'b1;
                        flush_e_s    = 1'b1;
                        state_next_s = ST_STALL;
                    end else begin
                        issue_s      = ValidD;
                        state_next_s = ST_RUN;
                    end
                end
                default: begin
                    state_next_s = ST_RUN;
                end
            endcase
        end
    end

    // Scoreboard next value: clears first, then the issuing set wins on the same index
    always_comb begin
        clr_w_s         = '0;
        clr_e_s         = '0;
        set_s           = '0;
        clr_w_s[WA3W]   = RegWriteW;
        clr_e_s[WA3E]   = SquashE & RegWriteE;
        set_s[WA3D]     = issue_s & RegWriteD & (WA3D != PC_IDX);
        sb_next_s       = (sb_r & ~clr_w_s & ~clr_e_s) | set_s;
    end

    // State, scoreboard, busy flag and saturating stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_RUN;
            sb_r        <= '0;
            busy_r      <= 1'b0;
            stall_cnt_r <= '0;
        end else begin
            state_r <= state_next_s;
            sb_r    <= sb_next_s;
            busy_r  <= |sb_next_s;
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    // Controls are held low while reset is asserted, independent of inputs
    assign StallF     = stall_s   & reset;
    assign StallD     = stall_s   & reset;
    assign FlushD     = flush_d_s & reset;
    assign FlushE     = flush_e_s & reset;
    assign Busy       = busy_r;
    assign StallCount = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int W = 4;
`ifdef HAZARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam bit NB = ~BYP;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] RA1D, RA2D, WA3D, WA3E, WA3W;
    logic UseRA1D, UseRA2D, ValidD, RegWriteD, SquashE, RegWriteE, RegWriteW, BranchTakenE;
    logic StallF, StallD, FlushD, FlushE, Busy;
    logic [W-1:0] StallCount;

    hazard_scoreboard #(.WIDTH(W), .NREGS(16), .PC_REG(15)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .UseRA1D(UseRA1D), .UseRA2D(UseRA2D),
        .ValidD(ValidD), .RegWriteD(RegWriteD), .WA3D(WA3D),
        .SquashE(SquashE), .WA3E(WA3E), .RegWriteE(RegWriteE),
        .RegWriteW(RegWriteW), .WA3W(WA3W), .BranchTakenE(BranchTakenE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .Busy(Busy), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic v, u1, u2, rwd, sqe, rwe, rww, br;
        logic [3:0] ra1, ra2, wa3d, wa3e, wa3w;
        logic es, efd, efe, eb;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic u1, input logic [3:0] ra1,
                                input logic u2, input logic [3:0] ra2,
                                input logic rwd, input logic [3:0] wa3d,
                                input logic sqe, input logic rwe, input logic [3:0] wa3e,
                                input logic rww, input logic [3:0] wa3w, input logic br,
                                input logic es, input logic efd, input logic efe, input logic eb);
        vec_t t;
        t.v = v; t.u1 = u1; t.ra1 = ra1; t.u2 = u2; t.ra2 = ra2;
        t.rwd = rwd; t.wa3d = wa3d; t.sqe = sqe; t.rwe = rwe; t.wa3e = wa3e;
        t.rww = rww; t.wa3w = wa3w; t.br = br;
        t.es = es; t.efd = efd; t.efe = efe; t.eb = eb;
        return t;
    endfunction

    task automatic drive_vec(input vec_t t);
        ValidD = t.v; UseRA1D = t.u1; RA1D = t.ra1; UseRA2D = t.u2; RA2D = t.ra2;
        RegWriteD = t.rwd; WA3D = t.wa3d; SquashE = t.sqe; RegWriteE = t.rwe; WA3E = t.wa3e;
        RegWriteW = t.rww; WA3W = t.wa3w; BranchTakenE = t.br;
    endtask

    task automatic drive_idle();
        drive_vec(mk(0,0,4'd0,0,4'd0,0,4'd0,0,0,4'd0,0,4'd0,0, 0,0,0,0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    bit pend_m[16];
    bit after_br_m;
    int cnt_m;
    bit e_st, e_fd, e_fe, issue_m;

    task automatic model_reset();
        foreach (pend_m[i]) pend_m[i] = 1'b0;
        after_br_m = 1'b0;
        cnt_m = 0;
    endtask

    function automatic bit pend_f(input logic [3:0] r);
        if (r == 4'd15) return 1'b0;
        if (BYP && RegWriteW && (WA3W == r)) return 1'b0;
        return pend_m[r];
    endfunction

    function automatic bit any_pend();
        bit a = 1'b0;
        foreach (pend_m[i]) a |= pend_m[i];
        return a;
    endfunction

    task automatic model_eval();
        bit hz;
        hz = ValidD && ((UseRA1D && pend_f(RA1D)) || (UseRA2D && pend_f(RA2D)) ||
                        (RegWriteD && pend_f(WA3D)));
        e_st = 1'b0; e_fd = 1'b0; e_fe = 1'b0;
        if (BranchTakenE) begin
            e_fd = 1'b1; e_fe = 1'b1;
        end else if (after_br_m) begin
            e_fd = 1'b1;
        end else if (hz) begin
            e_st = 1'b1; e_fe = 1'b1;
        end
        issue_m = ValidD && !hz && !BranchTakenE && !after_br_m;
    endtask

    task automatic model_commit();
        if (RegWriteW) pend_m[WA3W] = 1'b0;
        if (SquashE && RegWriteE) pend_m[WA3E] = 1'b0;
        if (issue_m && RegWriteD && (WA3D != 4'd15)) pend_m[WA3D] = 1'b1;
        after_br_m = BranchTakenE;
        if (e_st && cnt_m < 15) cnt_m++;
    endtask

    function automatic logic [3:0] rnd_reg();
        int unsigned r;
        r = $urandom_range(0, 8);
        if (r == 8) r = 15;
        return 4'(r);
    endfunction

    vec_t tbl[20];

    initial begin
        drive_idle();
        // table: v u1 ra1 u2 ra2 rwd wa3d sqe rwe wa3e rww wa3w br | stall fD fE busy
        tbl[0]  = mk(1,0,4'd0, 0,4'd0, 1,4'd4,  0,0,4'd0, 0,4'd0, 0,  0, 0,0, 0);
        tbl[1]  = mk(1,1,4'd4, 0,4'd0, 0,4'd0,  0,0,4'd0, 0,4'd0, 0,  1, 0,1, 1);
        tbl[2]  = mk(1,1,4'd4, 0,4'd0, 0,4'd0,  0,0,4'd0, 0,4'd0, 0,  1, 0,1, 1);
        tbl[3]  = mk(1,1,4'd4, 0,4'd0, 0,4'd0,  0,0,4'd0, 1,4'd4, 0, NB, 0,NB, 1);
        tbl[4]  = mk(1,1,4'd4, 0,4'd0, 0,4'd0,  0,0,4'd0, 0,4'd0, 0,  0, 0,0, 0);
        tbl[5]  = mk(1,1,4'd15,0,4'd0, 1,4'd15, 0,0,4'd0, 0,4'd0, 0,  0, 0,0, 0);
        tbl[6]  = mk(1,1,4'd15,0,4'd0, 0,4'd0,  0,0,4'd0, 0,4'd0, 0,  0, 0,0, 0);
        tbl[7]  = mk(1,0,4'd0, 0,4'd0, 1,4'd7,  0,0,4'd0, 0,4'd0, 0,  0, 0,0, 0);
        tbl[8]  = mk(1,0,4'd0, 0,4'd0, 1,4'd7,  0,0,4'd0, 0,4'd0, 0,  1, 0,1, 1);
        tbl[9]  = mk(1,0,4'd0, 0,4'd0, 1,4'd7,  0,0,4'd0, 1,4'd7, 0, NB, 0,NB, 1);
        tbl[10] = mk(0,0,4'd0, 0,4'd0, 0,4'd0,  0,0,4'd0, 1,4'd7, 0,  0, 0,0, BYP);
        tbl[11] = mk(1,0,4'd0, 0,4'd0, 1,4'd2,  0,0,4'd0, 0,4'd0, 0,  0, 0,0, 0);
        tbl[12] = mk(0,0,4'd0, 0,4'd0, 0,4'd0,  1,1,4'd2, 0,4'd0, 0,  0, 0,0, 1);
        tbl[13] = mk(1,1,4'd2, 0,4'd0, 0,4'd0,  0,0,4'd0, 0,4'd0, 0,  0, 0,0, 0);
        tbl[14] = mk(1,0,4'd0, 0,4'd0, 1,4'd9,  0,0,4'd0, 0,4'd0, 0,  0, 0,0, 0);
        tbl[15] = mk(1,0,4'd0, 1,4'd9, 1,4'd10, 0,0,4'd0, 0,4'd0, 0,  1, 0,1, 1);
        tbl[16] = mk(1,0,4'd0, 1,4'd9, 1,4'd10, 0,0,4'd0, 0,4'd0, 1,  0, 1,1, 1);
        tbl[17] = mk(1,0,4'd0, 0,4'd0, 1,4'd11, 0,0,4'd0, 0,4'd0, 0,  0, 1,0, 1);
        tbl[18] = mk(1,1,4'd10,1,4'd11,0,4'd0,  0,0,4'd0, 1,4'd9, 0,  0, 0,0, 1);
        tbl[19] = mk(0,0,4'd0, 0,4'd0, 0,4'd0,  0,0,4'd0, 0,4'd0, 0,  0, 0,0, 0);

        // reset state
        #12;
        chk("rst_stallf", StallF, 0); chk("rst_stalld", StallD, 0);
        chk("rst_flushd", FlushD, 0); chk("rst_flushe", FlushE, 0);
        chk("rst_busy", Busy, 0);     chk("rst_count", StallCount, 0);
        reset = 1'b1;
        step();

        // directed table
        for (int i = 0; i < 20; i++) begin
            drive_vec(tbl[i]);
            @(negedge clk);
            chk($sformatf("tbl%0d_stalld", i), StallD, tbl[i].es);
            chk($sformatf("tbl%0d_stallf", i), StallF, tbl[i].es);
            chk($sformatf("tbl%0d_flushd", i), FlushD, tbl[i].efd);
            chk($sformatf("tbl%0d_flushe", i), FlushE, tbl[i].efe);
            chk($sformatf("tbl%0d_busy", i), Busy, tbl[i].eb);
            step();
        end
        chk("table_stall_count", StallCount, 4 + 2 * int'(NB));

        // reset with a dirty scoreboard during a stall
        drive_vec(mk(1,0,4'd0,0,4'd0,1,4'd3,0,0,4'd0,0,4'd0,0, 0,0,0,0)); step();
        drive_vec(mk(1,0,4'd0,0,4'd0,1,4'd5,0,0,4'd0,0,4'd0,0, 0,0,0,0)); step();
        drive_vec(mk(1,1,4'd3,0,4'd0,0,4'd0,0,0,4'd0,0,4'd0,0, 0,0,0,0));
        @(negedge clk);
        chk("dirty_stalld", StallD, 1);
        chk("dirty_busy", Busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_stallf", StallF, 0); chk("arst_stalld", StallD, 0);
        chk("arst_flushd", FlushD, 0); chk("arst_flushe", FlushE, 0);
        chk("arst_busy", Busy, 0);     chk("arst_count", StallCount, 0);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_stalld", StallD, 0);
        step();
        chk("post_rst_busy", Busy, 0);

        // stall counter saturation
        drive_vec(mk(1,0,4'd0,0,4'd0,1,4'd6,0,0,4'd0,0,4'd0,0, 0,0,0,0)); step();
        drive_vec(mk(1,1,4'd6,0,4'd0,0,4'd0,0,0,4'd0,0,4'd0,0, 0,0,0,0));
        for (int i = 0; i < 10; i++) step();
        chk("sat_mid_count", StallCount, 10);
        for (int i = 0; i < 10; i++) step();
        @(negedge clk);
        chk("sat_stalld", StallD, 1);
        chk("sat_count", StallCount, 15);
        drive_idle();
        step();
        reset = 1'b0;
        #2 reset = 1'b1;
        step();
        model_reset();

        // randomized run against the reference model
        for (int c = 0; c < 400; c++) begin
            ValidD = ($urandom_range(0, 3) != 0);
            UseRA1D = 1'($urandom_range(0, 1)); RA1D = rnd_reg();
            UseRA2D = 1'($urandom_range(0, 1)); RA2D = rnd_reg();
            RegWriteD = 1'($urandom_range(0, 1)); WA3D = rnd_reg();
            SquashE = ($urandom_range(0, 5) == 0);
            RegWriteE = 1'($urandom_range(0, 1)); WA3E = rnd_reg();
            RegWriteW = ($urandom_range(0, 2) == 0); WA3W = rnd_reg();
            BranchTakenE = ($urandom_range(0, 11) == 0);
            @(negedge clk);
            model_eval();
            chk("rnd_stalld", StallD, e_st);
            chk("rnd_stallf", StallF, e_st);
            chk("rnd_flushd", FlushD, e_fd);
            chk("rnd_flushe", FlushE, e_fe);
            chk("rnd_busy", Busy, any_pend());
            chk("rnd_count", StallCount, cnt_m);
            model_commit();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
